// File: rtl/gs_normalize.sv
// gs_normalize: one column of a Gram-Schmidt QR step.
// Forms u = x - p, then ||u|| with a bit-serial square root, then q = u / ||u||
// with a bit-serial restoring divider, one element at a time.
// All values are Q16.16. rkk is the unsigned norm and saturates at 0xFFFF_FFFF.
// Define GS_NORM_SAT_EN to make x - p saturate on signed overflow instead of wrapping.
module gs_normalize #(
   parameter int M = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [M*32-1:0] x,
   input  logic [M*32-1:0] p,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [M*32-1:0] q,
   output logic [31:0]     rkk,
   output logic            degen
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SUB,
      ST_SQSUM,
      ST_SQRT,
      ST_DIV,
      ST_DONE
   } state_t;

   localparam int               IDX_W     = (M > 1) ? $clog2(M) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(M - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [5:0]       SQRT_LAST = 6'd32;   // 33 root bits
   localparam logic [5:0]       DIV_LAST  = 6'd31;   // 32 quotient bits

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [M-1:0][31:0]    x_q, x_d;        // captured column
   logic [M-1:0][31:0]    p_q, p_d;        // captured projection sum
   logic [M-1:0][31:0]    u_q, u_d;        // differences, overwritten by quotients
   logic [M-1:0][31:0]    q_q, q_d;        // published result
   logic [65:0]           acc_q, acc_d;    // sum of squares, Q32.32; shifted out by the root
   logic [33:0]           rem_q, rem_d;    // square-root partial remainder
   logic [32:0]           root_q, root_d;  // square-root result, Q16.16
   logic [32:0]           drem_q, drem_d;  // divider partial remainder (always < root)
   logic [31:0]           dvd_q, dvd_d;    // dividend bits shifting out, quotient shifting in
   logic [5:0]            cnt_q, cnt_d;    // bit counter inside SQRT / DIV
   logic [IDX_W-1:0]      idx_q, idx_d;    // element index for SQSUM / DIV
   logic [31:0]           rkk_q, rkk_d;
   logic                  degen_q, degen_d;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic [31:0] sub_elem(input logic [31:0] a, input logic [31:0] b);
`ifdef GS_NORM_SAT_EN
      logic [32:0] diff;
      diff = {a[31], a} - {b[31], b};
      if (diff[32] != diff[31]) begin
         sub_elem = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         sub_elem = diff[31:0];
      end
`else
      sub_elem = a - b;
`endif
   endfunction

   // Magnitude of a signed value; 0x8000_0000 maps to 2^31, which still fits unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      abs32 = v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] sat_rkk(input logic [32:0] n);
      sat_rkk = n[32] ? 32'hFFFF_FFFF : n[31:0];
   endfunction

   // ------------------------------------------------------------------
   // Per-cycle arithmetic steps
   // ------------------------------------------------------------------
   logic [31:0] sel_u;
   logic [31:0] sel_abs;
   logic [63:0] sel_sq;
   logic [35:0] sq_rem_sh;
   logic [35:0] sq_trial;
   logic [33:0] sq_rem_nxt;
   logic [32:0] sq_root_nxt;
   logic [32:0] dv_rem_cur;
   logic [31:0] dv_dvd_cur;
   logic [33:0] dv_rem_sh;
   logic [33:0] dv_divisor;
   logic        dv_ge;
   logic [32:0] dv_rem_nxt;
   logic [31:0] dv_dvd_nxt;
   logic [31:0] dv_q_signed;

   // Square of the selected element, one square-root digit and one quotient digit
   // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
   always_comb begin
      sel_u   = u_q[idx_q];
      sel_abs = abs32(sel_u);
      sel_sq  = {32'd0, sel_abs} * {32'd0, sel_abs};

      // Restoring square root: bring down the next two bits of S, try 4*root+1.
      sq_rem_sh = {rem_q, acc_q[65:64]};
      sq_trial  = {1'b0, root_q, 2'b01};
      if (sq_rem_sh >= sq_trial) begin
         sq_rem_nxt  = 34'(sq_rem_sh - sq_trial);
         sq_root_nxt = {root_q[31:0], 1'b1};
      end else begin
         sq_rem_nxt  = sq_rem_sh[33:0];
         sq_root_nxt = {root_q[31:0], 1'b0};
      end

      // Restoring divide of (|u| << 16) by the root. The top 16 dividend bits
      // seed the remainder; they are always below the root because |u| <= root.
      if (cnt_q == 6'd0) begin
         dv_rem_cur = {17'd0, sel_abs[31:16]};
         dv_dvd_cur = {sel_abs[15:0], 16'd0};
      end else begin
         dv_rem_cur = drem_q;
         dv_dvd_cur = dvd_q;
      end
      dv_rem_sh  = {dv_rem_cur, dv_dvd_cur[31]};
      dv_divisor = {1'b0, root_q};
      dv_ge      = (dv_rem_sh >= dv_divisor);
      if (dv_ge) begin
         dv_rem_nxt = 33'(dv_rem_sh - dv_divisor);
      end else begin
         dv_rem_nxt = dv_rem_sh[32:0];
      end
      dv_dvd_nxt  = {dv_dvd_cur[30:0], dv_ge};
      dv_q_signed = sel_u[31] ? (~dv_dvd_nxt + 32'd1) : dv_dvd_nxt;
   end

   // ------------------------------------------------------------------
   // FSM next state, register updates and handshake outputs
   // ------------------------------------------------------------------
   // Sequencing of SUB / SQSUM / SQRT / DIV / DONE and handshake outputs
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      p_d       = p_q;
      u_d       = u_q;
      q_d       = q_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      root_d    = root_q;
      drem_d    = drem_q;
      dvd_d     = dvd_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rkk_d     = rkk_q;
      degen_d   = degen_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               x_d     = x;
               p_d     = p;
               acc_d   = '0;
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ST_SUB;
            end
         end

         ST_SUB: begin
            for (int i = 0; i < M; i++) begin
               u_d[i] = sub_elem(x_q[i], p_q[i]);
            end
            state_d = ST_SQSUM;
         end

         ST_SQSUM: begin
            acc_d = acc_q + {2'd0, sel_sq};
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = ST_SQRT;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end

         ST_SQRT: begin
            acc_d  = {acc_q[63:0], 2'b00};
            rem_d  = sq_rem_nxt;
            root_d = sq_root_nxt;
            if (cnt_q == SQRT_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               if (sq_root_nxt == '0) begin
                  // Zero-length column: nothing to divide by.
                  q_d     = '0;
                  rkk_d   = '0;
                  degen_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DIV;
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         ST_DIV: begin
            drem_d = dv_rem_nxt;
            dvd_d  = dv_dvd_nxt;
            if (cnt_q == DIV_LAST) begin
               u_d[idx_q] = dv_q_signed;
               cnt_d      = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  q_d     = u_d;
                  rkk_d   = sat_rkk(root_q);
                  degen_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the operand and result arrays are cleared too, so q reads zero during and after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         p_q     <= '0;
         u_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         drem_q  <= '0;
         dvd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         rkk_q   <= '0;
         degen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         p_q     <= p_d;
         u_q     <= u_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         drem_q  <= drem_d;
         dvd_q   <= dvd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rkk_q   <= rkk_d;
         degen_q <= degen_d;
      end
   end

   assign q     = q_q;
   assign rkk   = rkk_q;
   assign degen = degen_q;

endmodule

// File: doc/gs_normalize.md
GS_NORMALIZE -- requirements
Module: gs_normalize

Interface
REQ-001 SHALL have parameter M, default 3, meaning vector length; element width fixed at 32 bits, signed Q16.16.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  x/p operands valid.
REQ-005 SHALL have port in_ready  output  1  block idle and able to accept.
REQ-006 SHALL have port x  input  M*32  column xk, element 0 in bits [31:0].
REQ-007 SHALL have port p  input  M*32  projection sum pk-1 from the projection stage, same packing.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port q  output  M*32  normalized column qk, signed Q16.16.
REQ-011 SHALL have port rkk  output  32  norm ||xk - pk-1||, unsigned Q16.16 (diagonal R entry).
REQ-012 SHALL have port degen  output  1  norm was zero; q forced to zero.

Function
REQ-013 SHALL run FSM IDLE -> SUB -> SQSUM -> SQRT -> DIV -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-014 SHALL, on in_valid&&in_ready, register x and p and enter SUB; x/p ignored in all other states.
REQ-015 SHALL in SUB (1 cycle) compute u[i]=x[i]-p[i] for all i, 32-bit result per REQ-030.
REQ-016 SHALL in SQSUM (M cycles, one element per cycle) accumulate S = sum u[i]^2 into a 66-bit unsigned accumulator (Q32.32), no overflow possible.
REQ-017 SHALL in SQRT (33 cycles) compute n = floor(sqrt(S)) with a bit-serial restoring square root, one result bit per cycle; n is Q16.16.
REQ-018 SHALL set rkk = n if n <= 0xFFFF_FFFF, else 0xFFFF_FFFF.
REQ-019 SHALL, if n == 0, set degen=1, q=all zero, rkk=0, and go SQRT -> DONE, skipping DIV.
REQ-020 SHALL in DIV (32 cycles per element, M elements sequentially, 32*M cycles) compute q[i] = sign(u[i]) * floor((|u[i]|<<16)/n) with a restoring divider; truncation toward zero.
REQ-021 SHALL assert out_valid in DONE and hold q, rkk, degen stable until out_valid&&out_ready, then return to IDLE on that edge.
REQ-022 SHALL have fixed latency from accept edge to out_valid high: 34+33*M cycles normal (133 for M=3), 34+M cycles degenerate (37 for M=3).
REQ-023 SHALL not accept a new input in the cycle results are consumed; in_ready rises the cycle after the DONE handshake.
REQ-024 SHALL keep q, rkk, degen at their last values outside DONE; only out_valid qualifies them.

Reset
REQ-025 SHALL on rst_n low immediately force FSM to IDLE, out_valid=0, q=0, rkk=0, degen=0, in_ready=1, all accumulators/counters to 0.
REQ-026 SHALL, if rst_n asserts mid-operation, abandon the operation with no output produced.
REQ-027 SHALL release reset synchronously to clk; first accept possible on the first rising edge with rst_n high.

Configuration
REQ-028 SHALL use macro GS_NORM_SAT_EN to compile in saturating subtraction.
REQ-029 SHALL, with GS_NORM_SAT_EN defined, clamp u[i] to 0x7FFF_FFFF / 0x8000_0000 on signed overflow.
REQ-030 SHALL, without GS_NORM_SAT_EN, compute u[i] as two's-complement wraparound modulo 2^32.

Verification
REQ-031 SHALL cover x=(3.0,4.0,0) [0x0003_0000,0x0004_0000,0], p=0 -> rkk=0x0005_0000, q=(0x0000_9999,0x0000_CCCC,0), degen=0, out_valid at cycle 133.
REQ-032 SHALL cover x=(-2.0,0,0), p=0 -> rkk=0x0002_0000, q=(0xFFFF_0000,0,0).
REQ-033 SHALL cover x=p=(1.0,1.0,1.0) -> degen=1, q=0, rkk=0, out_valid at cycle 37.
REQ-034 SHALL cover x[0]=0x7FFF_FFFF, p[0]=0x8000_0000, others 0 -> with GS_NORM_SAT_EN q[0]=0x0001_0000, rkk=0x7FFF_FFFF; without, u[0]=0xFFFF_FFFF, q[0]=0xFFFF_0000, rkk=0x0000_0001.
REQ-035 SHALL cover out_ready held low 10 cycles in DONE -> out_valid, q, rkk stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-036 SHALL cover rst_n pulsed low during DIV -> out_valid never asserts, in_ready=1 and outputs zero while reset is low; subsequent REQ-031 stimulus produces correct result.
